// File: rtl/user_reg_pkg.sv
// user_reg_pkg -- shared definitions for the user register bank.
//  REG_ADDR_RESET / REG_CMD_RESET : register and command used by the reset generator
//  REG_ADDR_COLL_CNT              : where the collision counter sits when DEPTH = 32
//  host_state_t                   : RBCP responder state
//  host_wr_t                      : host write request handed from the RBCP front end to storage
package user_reg_pkg;
  localparam logic [4:0] REG_ADDR_RESET    = 5'd1;
  localparam logic [7:0] REG_CMD_RESET     = 8'h0F;
  localparam logic [4:0] REG_ADDR_COLL_CNT = 5'd31;
  localparam int         MAX_DEPTH         = 32;

  typedef enum logic {IDLE, RESP} host_state_t;

  typedef struct packed {
    logic       we;
    logic [4:0] idx;
    logic [7:0] wd;
  } host_wr_t;
endpackage

// File: rtl/user_reg_rbcp_if.sv
// user_reg_rbcp_if -- SiTCP RBCP front end of the user register bank.
//  Decodes the RBCP byte address against the bank window, runs the IDLE/RESP
//  responder, emits the write request for the storage and returns ACK/RD.
//  Ports:
//   CLK, RST                 clock, async active-high reset
//   RBCP_ACT/ADDR/WE/WD/RE   RBCP host bus inputs
//   host_rdata               current value of the register selected by host_idx
//   RBCP_ACK, RBCP_RD        1-cycle acknowledge and read data
//   host_idx                 register index derived from RBCP_ADDR
//   host_wr                  host write request (valid on the strobe cycle)
module user_reg_rbcp_if
  import user_reg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RBCP_ACT,
  input  logic [31:0] RBCP_ADDR,
  input  logic        RBCP_WE,
  input  logic [7:0]  RBCP_WD,
  input  logic        RBCP_RE,
  input  logic [7:0]  host_rdata,
  output logic        RBCP_ACK,
  output logic [7:0]  RBCP_RD,
  output logic [4:0]  host_idx,
  output host_wr_t    host_wr
);

  host_state_t state, state_nxt;
  logic [31:0] offset;
  logic        hit, start;
  logic [7:0]  rd_q;

  // Subtract first, then bound the offset: avoids overflow of BASE_ADDR+DEPTH.
  assign offset   = RBCP_ADDR - BASE_ADDR;
  assign hit      = (RBCP_ADDR >= BASE_ADDR) && (offset < 32'(DEPTH));
  assign host_idx = offset[4:0];
  // Strobes seen while in RESP are dropped here.
  assign start    = (state == IDLE) && RBCP_ACT && (RBCP_WE || RBCP_RE) && hit;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      rd_q  <= 8'h00;
    end else begin
      state <= state_nxt;
      // Sampled on the strobe edge, so a combined WE+RE returns the pre-write value.
      if (start) rd_q <= host_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ACK decodes straight from the state so an async reset drops it immediately.
  always_comb begin
    RBCP_ACK   = (state == RESP);
    RBCP_RD    = RBCP_ACK ? rd_q : 8'h00;
    host_wr.we  = start && RBCP_WE;
    host_wr.idx = host_idx;
    host_wr.wd  = RBCP_WD;
  end

endmodule

// File: rtl/user_reg_bank8.sv
// user_reg_bank8 -- DEPTH x 8-bit dual-port user register bank.
//  Port A is the SiTCP RBCP host bus (via user_reg_rbcp_if), port B is the
//  user-logic side: registered polled read (0x00 when disabled), pulsed write.
//  Host write beats port B write to the same register on the same edge.
//  Optional: define USER_REG_COLL_CNT_EN to turn register DEPTH-1 into a
//  read-only saturating count of dropped port B writes; any host write there clears it.
//  Ports:
//   CLK, RST                          clock, async active-high reset
//   RBCP_ACT/ADDR/WE/WD/RE/ACK/RD     RBCP host bus
//   port_b_en/addr/we/wdata/rdata     user-side access port
module user_reg_bank8
  import user_reg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 32,
  parameter logic [7:0]  INIT_VAL  = 8'h00
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RBCP_ACT,
  input  logic [31:0] RBCP_ADDR,
  input  logic        RBCP_WE,
  input  logic [7:0]  RBCP_WD,
  input  logic        RBCP_RE,
  output logic        RBCP_ACK,
  output logic [7:0]  RBCP_RD,
  input  logic        port_b_en,
  input  logic [4:0]  port_b_addr,
  input  logic        port_b_we,
  input  logic [7:0]  port_b_wdata,
  output logic [7:0]  port_b_rdata
);

`ifdef USER_REG_COLL_CNT_EN
  localparam int WR_LIMIT = DEPTH - 1;   // top register belongs to the counter
`else
  localparam int WR_LIMIT = DEPTH;
`endif

  // Full 32-entry storage; entries at/above WR_LIMIT never leave INIT_VAL and trim away.
  logic [MAX_DEPTH-1:0][7:0] regs;
  logic [7:0] host_rdata, pb_val;
  logic [4:0] host_idx;
  host_wr_t   host_wr;
  logic       pb_hit, pb_wr;

  user_reg_rbcp_if #(.BASE_ADDR(BASE_ADDR), .DEPTH(DEPTH)) u_rbcp (
    .CLK        (CLK),
    .RST        (RST),
    .RBCP_ACT   (RBCP_ACT),
    .RBCP_ADDR  (RBCP_ADDR),
    .RBCP_WE    (RBCP_WE),
    .RBCP_WD    (RBCP_WD),
    .RBCP_RE    (RBCP_RE),
    .host_rdata (host_rdata),
    .RBCP_ACK   (RBCP_ACK),
    .RBCP_RD    (RBCP_RD),
    .host_idx   (host_idx),
    .host_wr    (host_wr)
  );

  assign pb_hit = (int'(port_b_addr) < DEPTH);
  assign pb_wr  = port_b_en && port_b_we && pb_hit;

`ifdef USER_REG_COLL_CNT_EN
  localparam logic [4:0] CNT_IDX = 5'(DEPTH - 1);
  logic [7:0] coll_cnt;
  logic       pb_drop;

  assign pb_drop = pb_wr && host_wr.we && (host_wr.idx == port_b_addr);

  // Host clear wins over a same-edge increment.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                         coll_cnt <= 8'h00;
    else if (host_wr.we && host_wr.idx == CNT_IDX)   coll_cnt <= 8'h00;
    else if (pb_drop && coll_cnt != 8'hFF)           coll_cnt <= coll_cnt + 8'h01;
  end
`endif

  always_comb begin
    host_rdata = regs[host_idx];
    pb_val     = pb_hit ? regs[port_b_addr] : 8'h00;
`ifdef USER_REG_COLL_CNT_EN
    if (host_idx == CNT_IDX)           host_rdata = coll_cnt;
    if (pb_hit && port_b_addr == CNT_IDX) pb_val  = coll_cnt;
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      regs <= {MAX_DEPTH{INIT_VAL}};
    end else begin
      for (int i = 0; i < WR_LIMIT; i++) begin
        if (host_wr.we && host_wr.idx == 5'(i))
          regs[i] <= host_wr.wd;
        else if (pb_wr && port_b_addr == 5'(i))
          regs[i] <= port_b_wdata;
      end
    end
  end

  // Forced to 0x00 when disabled so pollers see a fresh 0x00 -> value edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) port_b_rdata <= 8'h00;
    else     port_b_rdata <= port_b_en ? pb_val : 8'h00;
  end

endmodule
